lcd_spi_rx: RTL and testbench

//  4-wire SPI receiver for the ILI9341V-style LCD link (CSX, DCX, SCK, SDO); the slave end of our LCD SPI transmitter.

---
 rtl/lcd_spi_rx.sv | 153 +++++++++++++++
 tb/tb_lcd_spi_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_rx.sv
// Slave-side 4-wire SPI receiver for the LCD link: deserialises DCX-tagged
// bytes into a small FWFT FIFO and tracks the current command/parameter count.
module lcd_spi_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csx,
    input  logic                          dcx,
    input  logic                          sck,
    input  logic                          sdo,
    output logic [7:0]                    rx_data,
    output logic                          rx_dc,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    cur_cmd,
    output logic [CNT_W-1:0]              param_cnt,
    output logic                          ovf,
    output logic                          frm_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic             r_csx, r_dcx, r_sck, r_sdo, r_sck_d;
    state_t           r_state;
    logic [2:0]       r_bitcnt;
    logic [6:0]       r_shreg;
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_level;
    logic [7:0]       r_cmd;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_ovf, r_frm;

    logic       w_rise, w_done, w_frm_set;
    logic       w_full, w_pop, w_wr, w_drop;
    logic [7:0] w_byte;
    logic [8:0] w_head;

    assign w_rise    = r_sck & ~r_sck_d;
    assign w_done    = (r_state == S_SHIFT) & ~r_csx & w_rise
                     & (r_bitcnt == 3'd7);
    assign w_frm_set = (r_state == S_SHIFT) & r_csx & (r_bitcnt != 3'd0);
    assign w_byte    = {r_shreg, r_sdo};
    assign w_full    = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr      = w_done & (~w_full | w_pop);
    assign w_drop    = w_done & w_full & ~w_pop;
    assign w_head    = r_mem[r_rptr];

    assign rx_data    = w_head[7:0];
    assign rx_dc      = w_head[8];
    assign rx_valid   = (r_level != '0);
    assign fifo_level = r_level;
    assign cur_cmd    = r_cmd;
    assign param_cnt  = r_pcnt;
    assign ovf        = r_ovf;
    assign frm_err    = r_frm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csx   <= 1'b1;
            r_dcx   <= 1'b0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_sck_d <= 1'b0;
        end else begin
            r_csx   <= csx;
            r_dcx   <= dcx;
            r_sck   <= sck;
            r_sdo   <= sdo;
            r_sck_d <= r_sck;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shreg  <= 7'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_bitcnt <= 3'd0;
                    if (!r_csx) begin
                        r_state <= S_SHIFT;
                        if (w_rise) begin
                            r_shreg  <= {r_shreg[5:0], r_sdo};
                            r_bitcnt <= 3'd1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_csx) begin
                        r_state  <= S_IDLE;
                        r_bitcnt <= 3'd0;
                    end else if (w_rise) begin
                        r_shreg  <= {r_shreg[5:0], r_sdo};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 9'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= {r_dcx, w_byte};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_wr && !w_pop)      r_level <= r_level + (AW+1)'(1);
            else if (!w_wr && w_pop) r_level <= r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd  <= 8'd0;
            r_pcnt <= '0;
            r_ovf  <= 1'b0;
            r_frm  <= 1'b0;
        end else begin
            if (w_wr) begin
                if (!r_dcx) begin
                    r_cmd  <= w_byte;
                    r_pcnt <= '0;
                end else if (r_pcnt != '1) begin
                    r_pcnt <= r_pcnt + CNT_W'(1);
                end
            end
            // Set beats clear when both land in the same cycle.
            if (w_drop)       r_ovf <= 1'b1;
            else if (err_clr) r_ovf <= 1'b0;
            if (w_frm_set)    r_frm <= 1'b1;
            else if (err_clr) r_frm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Scoreboard bench for lcd_spi_rx: bytes expected to land in the FIFO are
// queued when sent and matched as the consumer pops them.
module tb_lcd_spi_rx;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       csx = 1'b1, dcx = 1'b0, sck = 1'b0, sdo = 1'b0;
    logic       rx_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid;
    logic [2:0] fifo_level;
    logic [7:0] cur_cmd;
    logic [7:0] param_cnt;
    logic       ovf, frm_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] sb[$];

    lcd_spi_rx #(.FIFO_DEPTH(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .csx(csx), .dcx(dcx), .sck(sck),
        .sdo(sdo), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_level(fifo_level), .cur_cmd(cur_cmd),
        .param_cnt(param_cnt), .ovf(ovf), .frm_err(frm_err),
        .err_clr(err_clr)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", {rx_dc, rx_data}, 32'h1ff);
            end else begin
                chk("rx_byte", {rx_dc, rx_data}, sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] b,
                             input int n);
        for (int i = 7; i > 7 - n; i--) begin
            tick(1);
            sck = 1'b0; dcx = dc; sdo = b[i];
            tick(1);
            sck = 1'b1;
        end
    endtask

    // act: 0 none, 1 pulse rx_ready, 2 pulse err_clr in the write cycle
    task automatic send_byte(input logic dc, input logic [7:0] b,
                             input bit exp_push, input int act,
                             input bit lat);
        if (exp_push) sb.push_back({dc, b});
        send_bits(dc, b, 8);
        @(negedge clk);
        if (lat) chk("lat_edge0", rx_valid, 0);
        tick(1);
        if (act == 1) rx_ready = 1'b1;
        if (act == 2) err_clr = 1'b1;
        @(negedge clk);
        if (lat) chk("lat_edge1", rx_valid, 0);
        tick(1);
        if (act == 1) rx_ready = 1'b0;
        if (act == 2) err_clr = 1'b0;
        sck = 1'b0;
        @(negedge clk);
        if (lat) chk("lat_edge2", rx_valid, 1);
    endtask

    task automatic drain();
        int k = 0;
        rx_ready = 1'b1;
        while ((sb.size() != 0 || rx_valid) && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
        chk("drain_valid", rx_valid, 0);
        chk("drain_level", fifo_level, 0);
    endtask

    initial begin
        tick(3);
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_cmd", cur_cmd, 0);
        chk("rst_pcnt", param_cnt, 0);
        chk("rst_errs", {ovf, frm_err}, 0);
        chk("rst_head", {rx_dc, rx_data}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        csx = 1'b0;
        tick(2);

        // command with two parameters
        rx_ready = 1'b1;
        send_byte(1'b0, 8'h2A, 1, 0, 0);
        send_byte(1'b1, 8'h00, 1, 0, 0);
        send_byte(1'b1, 8'h10, 1, 0, 0);
        drain();
        chk("t1_cmd", cur_cmd, 8'h2A);
        chk("t1_pcnt", param_cnt, 2);

        // 16-bit word, latency on the high byte
        send_byte(1'b1, 8'hF8, 1, 0, 1);
        send_byte(1'b1, 8'h1F, 1, 0, 0);
        drain();
        chk("t2_pcnt", param_cnt, 4);

        // overflow: five bytes into four slots
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_byte(1'b1, 8'h30 + 8'(i), i < D, 0, 0);
        @(negedge clk);
        chk("t3_level", fifo_level, D);
        chk("t3_ovf", ovf, 1);
        chk("t3_pcnt", param_cnt, 8);

        // write with coincident pop at full
        send_byte(1'b1, 8'h99, 1, 1, 0);
        chk("t6_level_pp", fifo_level, D);
        chk("t6_ovf_kept", ovf, 1);
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("t6_ovf_clr", ovf, 0);
        // err_clr coincident with a fresh drop
        send_byte(1'b1, 8'h77, 0, 2, 0);
        chk("t6_ovf_set", ovf, 1);
        chk("t6_level", fifo_level, D);
        drain();
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // CSX rises mid-byte
        send_bits(1'b1, 8'b1010_0000, 3);
        tick(1);
        sck = 1'b0;
        tick(1);
        csx = 1'b1;
        tick(3);
        @(negedge clk);
        chk("t4_frm", frm_err, 1);
        chk("t4_level", fifo_level, 0);
        tick(1);
        csx = 1'b0;
        tick(2);
        send_byte(1'b1, 8'h55, 1, 0, 0);
        drain();
        chk("t4_frm_kept", frm_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_frm_clr", frm_err, 0);

        // reset mid-byte with the FIFO half full
        rx_ready = 1'b0;
        send_byte(1'b0, 8'h3C, 1, 0, 0);
        send_byte(1'b1, 8'h11, 1, 0, 0);
        send_bits(1'b1, 8'hF0, 4);
        tick(1);
        sck = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t5_valid", rx_valid, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_cmd", cur_cmd, 0);
        chk("t5_pcnt", param_cnt, 0);
        chk("t5_head", {rx_dc, rx_data}, 0);
        chk("t5_errs", {ovf, frm_err}, 0);
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        tick(3);
        rx_ready = 1'b1;
        send_byte(1'b1, 8'hA5, 1, 0, 0);
        drain();
        chk("t5_pcnt_after", param_cnt, 1);
        chk("t5_frm_after", frm_err, 0);

        // parameter counter saturation
        send_byte(1'b0, 8'h2C, 1, 0, 0);
        for (int i = 0; i < 256; i++)
            send_byte(1'b1, 8'(i), 1, 0, 0);
        drain();
        chk("sat_pcnt", param_cnt, 8'hFF);
        chk("sat_cmd", cur_cmd, 8'h2C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got stuck, expected finish");
        $fatal(1, "timeout");
    end

endmodule
